cell_plotter: RTL and testbench

- Consumes the mouse interface's registered grid outputs (cell_x, cell_y, button_left/right/middle) and turns them into per-pixel write requests for the VGA frame-buffer adapter.
- Left button paints the current 5x5 cell in the selected colour; right button erases it to background.
- A rising edge on the middle button clears the whole screen.
- Sits between the PS/2 mouse block and the VGA adapter, all on CLOCK_50.

---
 rtl/cell_plotter_if.sv | 34 +++
 rtl/cell_plotter.sv | 209 ++++++++++++++++++++
 tb/tb_cell_plotter.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_plotter_if.sv
// Mouse-side grid inputs and frame-buffer-side pixel writes for cell_plotter.
// master drives the mouse grid signals and observes the pixel stream; slave is the plotter.
interface cell_plotter_if #(
    parameter int unsigned CELL_BITS   = 7,
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 9,
    parameter int unsigned COLOUR_BITS = 3
);
    // Grid selection and buttons, as registered by the mouse block
    logic [CELL_BITS-1:0]   cell_x;
    logic [CELL_BITS-1:0]   cell_y;
    logic                   button_left;
    logic                   button_right;
    logic                   button_middle;
    logic [COLOUR_BITS-1:0] colour_sel;

    // Pixel write stream towards the VGA adapter
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      y;
    logic [COLOUR_BITS-1:0] colour;
    logic                   plot;
    logic                   busy;
    logic                   done;

    modport master (
        output cell_x, cell_y, button_left, button_right, button_middle, colour_sel,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  cell_x, cell_y, button_left, button_right, button_middle, colour_sel,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/cell_plotter.sv
// Turns mouse grid selections into per-pixel frame-buffer writes.
// Left paints a 5x5 cell, right erases it, a middle-button rising edge clears the screen.
module cell_plotter #(
    parameter int unsigned SCREEN_WIDTH   = 640,
    parameter int unsigned SCREEN_HEIGHT  = 480,
    parameter int unsigned CELL_DIMENSION = 5,
    parameter int unsigned COLOUR_BITS    = 3,
    parameter int unsigned BG_COLOUR      = 0
) (
    input logic          CLOCK_50,
    input logic          reset,
    cell_plotter_if.slave bus
);
    localparam int unsigned MAX_DIM   = (SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH
                                                                        : SCREEN_HEIGHT;
    localparam int unsigned CELL_BITS = $clog2(MAX_DIM / CELL_DIMENSION);
    localparam int unsigned X_BITS    = $clog2(SCREEN_WIDTH);
    localparam int unsigned Y_BITS    = $clog2(SCREEN_HEIGHT);
    localparam int unsigned CELLS_X   = SCREEN_WIDTH / CELL_DIMENSION;
    localparam int unsigned CELLS_Y   = SCREEN_HEIGHT / CELL_DIMENSION;

    localparam logic [X_BITS-1:0]      CELL_DIM_X    = X_BITS'(CELL_DIMENSION);
    localparam logic [Y_BITS-1:0]      CELL_DIM_Y    = Y_BITS'(CELL_DIMENSION);
    localparam logic [X_BITS-1:0]      CELL_LAST_X   = X_BITS'(CELL_DIMENSION - 1);
    localparam logic [Y_BITS-1:0]      CELL_LAST_Y   = Y_BITS'(CELL_DIMENSION - 1);
    localparam logic [X_BITS-1:0]      SCREEN_LAST_X = X_BITS'(SCREEN_WIDTH - 1);
    localparam logic [Y_BITS-1:0]      SCREEN_LAST_Y = Y_BITS'(SCREEN_HEIGHT - 1);
    localparam logic [COLOUR_BITS-1:0] BG            = COLOUR_BITS'(BG_COLOUR);

    // ST_FLUSH is the single cycle that retires plot and raises done
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PAINT = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [X_BITS-1:0]      px_q, px_d;
    logic [Y_BITS-1:0]      py_q, py_d;
    logic [X_BITS-1:0]      base_x_q, base_x_d;
    logic [Y_BITS-1:0]      base_y_q, base_y_d;
    logic [COLOUR_BITS-1:0] col_q, col_d;
    logic [X_BITS-1:0]      x_q, x_d;
    logic [Y_BITS-1:0]      y_q, y_d;
    logic [COLOUR_BITS-1:0] colour_q, colour_d;
    logic                   plot_q, plot_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mid_q, mid_d;
    logic                   last_valid_q, last_valid_d;
    logic [CELL_BITS-1:0]   last_cx_q, last_cx_d;
    logic [CELL_BITS-1:0]   last_cy_q, last_cy_d;
    logic [COLOUR_BITS-1:0] last_col_q, last_col_d;

    logic                   mid_rise;
    logic                   req_any;
    logic                   req_in_range;
    logic                   req_dup;
    logic                   req_accept;
    logic [COLOUR_BITS-1:0] req_col;

    // Decode the sampled request: left beats right, duplicates and off-screen cells are dropped
    always_comb begin
        mid_rise     = bus.button_middle & ~mid_q;
        req_any      = bus.button_left | bus.button_right;
        req_col      = bus.button_left ? bus.colour_sel : BG;
        req_in_range = (32'(bus.cell_x) < CELLS_X) && (32'(bus.cell_y) < CELLS_Y);
        req_dup      = last_valid_q && (bus.cell_x == last_cx_q) &&
                       (bus.cell_y == last_cy_q) && (req_col == last_col_q);
        req_accept   = req_any && req_in_range && !req_dup;
    end

    // Next-state: request acceptance, pixel scan for paint and clear, completion pulse
    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        col_d        = col_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        // Tracked every cycle so that middle edges arriving while busy are forgotten
        mid_d        = bus.button_middle;
        last_valid_d = last_valid_q;
        last_cx_d    = last_cx_q;
        last_cy_d    = last_cy_q;
        last_col_d   = last_col_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (mid_rise) begin
                    state_d      = ST_CLEAR;
                    busy_d       = 1'b1;
                    px_d         = '0;
                    py_d         = '0;
                    col_d        = BG;
                    // After a clear every cell is background, so nothing may be skipped
                    last_valid_d = 1'b0;
                end else if (req_accept) begin
                    state_d      = ST_PAINT;
                    busy_d       = 1'b1;
                    px_d         = '0;
                    py_d         = '0;
                    base_x_d     = X_BITS'(bus.cell_x) * CELL_DIM_X;
                    base_y_d     = Y_BITS'(bus.cell_y) * CELL_DIM_Y;
                    col_d        = req_col;
                    last_valid_d = 1'b1;
                    last_cx_d    = bus.cell_x;
                    last_cy_d    = bus.cell_y;
                    last_col_d   = req_col;
                end
            end
            ST_PAINT: begin
                x_d      = base_x_q + px_q;
                y_d      = base_y_q + py_q;
                colour_d = col_q;
                plot_d   = 1'b1;
                if (px_q == CELL_LAST_X) begin
                    px_d = '0;
                    if (py_q == CELL_LAST_Y) begin
                        state_d = ST_FLUSH;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                x_d      = px_q;
                y_d      = py_q;
                colour_d = col_q;
                plot_d   = 1'b1;
                if (px_q == SCREEN_LAST_X) begin
                    px_d = '0;
                    if (py_q == SCREEN_LAST_Y) begin
                        state_d = ST_FLUSH;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            px_q         <= '0;
            py_q         <= '0;
            base_x_q     <= '0;
            base_y_q     <= '0;
            col_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mid_q        <= 1'b0;
            last_valid_q <= 1'b0;
            last_cx_q    <= '0;
            last_cy_q    <= '0;
            last_col_q   <= '0;
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            col_q        <= col_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mid_q        <= mid_d;
            last_valid_q <= last_valid_d;
            last_cx_q    <= last_cx_d;
            last_cy_q    <= last_cy_d;
            last_col_q   <= last_col_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: full-size instance for paint/erase/priority/reset behaviour,
// plus a 40x30 instance so a complete screen clear fits in a short run.
module tb_cell_plotter;
    localparam int W   = 640;
    localparam int H   = 480;
    localparam int CD  = 5;
    localparam int SW  = 40;
    localparam int SH  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s_n = 1'b0;

    always #5 clk = ~clk;

    cell_plotter_if #(.CELL_BITS(7), .X_BITS(10), .Y_BITS(9), .COLOUR_BITS(3)) bif ();
    cell_plotter_if #(.CELL_BITS(3), .X_BITS(6), .Y_BITS(5), .COLOUR_BITS(3)) sif ();

    cell_plotter #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .CELL_DIMENSION(CD), .COLOUR_BITS(3), .BG_COLOUR(0)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst_n),
        .bus     (bif.slave)
    );

    cell_plotter #(
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .CELL_DIMENSION(CD), .COLOUR_BITS(3),
        .BG_COLOUR(0)
    ) dut_small (
        .CLOCK_50(clk),
        .reset   (rst_s_n),
        .bus     (sif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Captured burst and expected burst
    int gx[$];
    int gy[$];
    int gc[$];
    int ex_q[$];
    int ey_q[$];
    int ec_q[$];

    // Reference record of the last drawn cell (what a duplicate request is compared against)
    bit m_valid = 1'b0;
    int m_cx, m_cy, m_col;

    // Reference model: a painted cell covers 5x5 pixels, row-major from its top-left corner
    task automatic model_paint(input int cx, input int cy, input int col);
        ex_q.delete(); ey_q.delete(); ec_q.delete();
        for (int i = 0; i < CD * CD; i++) begin
            ex_q.push_back(cx * CD + i % CD);
            ey_q.push_back(cy * CD + i / CD);
            ec_q.push_back(col);
        end
    endtask

    // Gathers one plot burst from the full-size instance (no judging, just recording)
    task automatic collect_burst(input int max_wait, input int max_len, output int lat,
                                 output int n, output bit end_done, output bit end_busy);
        gx.delete(); gy.delete(); gc.delete();
        lat = 0; n = 0; end_done = 1'b0; end_busy = 1'b1;
        @(negedge clk);
        while (!bif.plot && lat < max_wait) begin
            lat++;
            @(negedge clk);
        end
        while (n < max_len) begin
            if (!bif.plot) break;
            gx.push_back(int'(bif.x));
            gy.push_back(int'(bif.y));
            gc.push_back(int'(bif.colour));
            n++;
            if (n == max_len) break;
            @(negedge clk);
        end
        if (!bif.plot) begin
            end_done = bif.done;
            end_busy = bif.busy;
        end
    endtask

    task automatic drive(input int cx, input int cy, input int col, input bit l, input bit r);
        bif.cell_x = 7'(cx);
        bif.cell_y = 7'(cy);
        bif.colour_sel = 3'(col);
        bif.button_left = l;
        bif.button_right = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_s_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.x !== 10'd0 || bif.y !== 9'd0 || bif.colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_xyc: got x=%0d y=%0d c=%0d, want 0 0 0", bif.x, bif.y, bif.colour);
        end
        checks++;
        if (bif.plot !== 1'b0 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got plot=%b busy=%b done=%b, want 0 0 0",
                     bif.plot, bif.busy, bif.done);
        end
        checks++;
        if (sif.plot !== 1'b0 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: got plot=%b busy=%b, want 0 0", sif.plot, sif.busy);
        end
    endtask

    task automatic test_first_paint();
        int lat, n;
        bit ed, eb;
        drive(0, 0, 4, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1 || bif.plot !== 1'b0) begin
            errors++;
            $display("FAIL first_accept: got busy=%b plot=%b, want busy=1 plot=0",
                     bif.busy, bif.plot);
        end
        model_paint(0, 0, 4);
        collect_burst(10, 40, lat, n, ed, eb);
        checks++;
        if (lat != 0 || n != 25) begin
            errors++;
            $display("FAIL first_shape: got lat=%0d n=%0d, want lat=0 n=25", lat, n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL first_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        checks++;
        if (ed !== 1'b1 || eb !== 1'b0) begin
            errors++;
            $display("FAIL first_done: got done=%b busy=%b, want done=1 busy=0", ed, eb);
        end
        @(negedge clk);
        checks++;
        if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL first_done_pulse: got done=%b busy=%b, want 0 0", bif.done, bif.busy);
        end
        m_valid = 1'b1; m_cx = 0; m_cy = 0; m_col = 4;
    endtask

    task automatic test_hold_dedup();
        int lat, n, extra;
        bit ed, eb;
        drive(3, 2, 4, 1'b1, 1'b0);
        model_paint(3, 2, 4);
        collect_burst(10, 40, lat, n, ed, eb);
        checks++;
        if (lat != 1 || n != 25) begin
            errors++;
            $display("FAIL hold_shape: got lat=%0d n=%0d, want lat=1 n=25", lat, n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL hold_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (bif.plot) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL hold_dedup: got %0d plot cycles, want 0", extra);
        end
        bif.colour_sel = 3'd2;
        model_paint(3, 2, 2);
        collect_burst(10, 40, lat, n, ed, eb);
        checks++;
        if (n != 25 || gc.size() == 0 || gc[0] != 2 || gx[24 % (n > 0 ? n : 1)] != ex_q[24]) begin
            errors++;
            $display("FAIL hold_recolour: got n=%0d, want 25 pixels of colour 2 ending at x=%0d",
                     n, ex_q[24]);
        end
        m_valid = 1'b1; m_cx = 3; m_cy = 2; m_col = 2;
    endtask

    task automatic test_right_and_priority();
        int lat, n;
        bit ed, eb;
        drive(127, 95, 6, 1'b0, 1'b1);
        model_paint(127, 95, 0);
        collect_burst(10, 40, lat, n, ed, eb);
        checks++;
        if (n != 25) begin
            errors++;
            $display("FAIL erase_len: got n=%0d, want 25", n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL erase_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        drive(1, 1, 5, 1'b1, 1'b1);
        model_paint(1, 1, 5);
        collect_burst(10, 40, lat, n, ed, eb);
        checks++;
        if (n != 25) begin
            errors++;
            $display("FAIL prio_len: got n=%0d, want 25", n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL prio_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        m_valid = 1'b1; m_cx = 1; m_cy = 1; m_col = 5;
        drive(1, 1, 5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int seen;
        // Row 96 is the first row past the bottom; column 128 is not representable in 7 bits
        drive(127, 96, 3, 1'b1, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.plot || bif.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL range_row96: got %0d active cycles, want 0", seen);
        end
        drive(0, 120, 3, 1'b0, 1'b1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.plot || bif.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL range_row120: got %0d active cycles, want 0", seen);
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, n, extra;
        bit ed, eb;
        drive(20, 30, 1, 1'b1, 1'b0);
        model_paint(20, 30, 1);
        fork
            collect_burst(10, 40, lat, n, ed, eb);
            begin
                repeat (6) @(negedge clk);
                bif.cell_x = 7'd21;
                bif.colour_sel = 3'd7;
                bif.button_middle = 1'b1;
                repeat (2) @(negedge clk);
                bif.button_middle = 1'b0;
            end
        join
        checks++;
        if (n != 25) begin
            errors++;
            $display("FAIL b2b_first_len: got n=%0d, want 25", n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL b2b_first_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        checks++;
        if (ed !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got done=%b, want 1", ed);
        end
        model_paint(21, 30, 7);
        collect_burst(10, 40, lat, n, ed, eb);
        // Plot was low for the done cycle plus this one IDLE sampling cycle
        checks++;
        if (lat != 1 || n != 25) begin
            errors++;
            $display("FAIL b2b_gap: got lat=%0d n=%0d, want lat=1 n=25", lat, n);
        end
        for (int i = 0; i < n && i < 25; i++) begin
            checks++;
            if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                errors++;
                $display("FAIL b2b_second_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
            end
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.plot) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_mid_ignored: got %0d plot cycles, want 0", extra);
        end
        m_valid = 1'b1; m_cx = 21; m_cy = 30; m_col = 7;
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_paint();
        int cnt, seen;
        drive(10, 10, 6, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 12; k++) begin
            @(negedge clk);
            if (bif.plot) cnt++;
        end
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL rstmid_reach: got %0d pixels, want 12", cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bif.plot !== 1'b0 || bif.busy !== 1'b0 || bif.x !== 10'd0 || bif.y !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_abort: got plot=%b busy=%b x=%0d y=%0d, want 0 0 0 0",
                     bif.plot, bif.busy, bif.x, bif.y);
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.plot || bif.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int cx, cy, col, btn, rcol, lat, n, seen;
            bit draw, ed, eb;
            cx = $urandom_range(0, 127);
            cy = $urandom_range(0, 105);
            col = $urandom_range(0, 7);
            btn = $urandom_range(0, 3);
            if (it % 6 == 5 && m_valid) begin
                cx = m_cx; cy = m_cy; col = m_col; btn = 1;
            end
            rcol = ((btn & 1) != 0) ? col : 0;
            draw = (btn != 0) && (cy < H / CD) &&
                   !(m_valid && cx == m_cx && cy == m_cy && rcol == m_col);
            drive(cx, cy, col, (btn & 1) != 0, (btn & 2) != 0);
            if (draw) begin
                model_paint(cx, cy, rcol);
                collect_burst(10, 40, lat, n, ed, eb);
                checks++;
                if (lat != 1 || n != 25 || ed !== 1'b1) begin
                    errors++;
                    $display("FAIL rand%0d_shape: got lat=%0d n=%0d done=%b, want 1 25 1",
                             it, lat, n, ed);
                end
                for (int i = 0; i < n && i < 25; i++) begin
                    checks++;
                    if (gx[i] != ex_q[i] || gy[i] != ey_q[i] || gc[i] != ec_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_pixel %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                 it, i, gx[i], gy[i], gc[i], ex_q[i], ey_q[i], ec_q[i]);
                    end
                end
                m_valid = 1'b1; m_cx = cx; m_cy = cy; m_col = rcol;
            end else begin
                seen = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (bif.plot || bif.busy) seen++;
                end
                checks++;
                if (seen != 0) begin
                    errors++;
                    $display("FAIL rand%0d_idle: cell (%0d,%0d) btn=%0d got %0d active, want 0",
                             it, cx, cy, btn, seen);
                end
            end
            drive(0, 0, 0, 1'b0, 1'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_clear_start();
        int lat, n, bad;
        bit ed, eb;
        drive(2, 2, 3, 1'b1, 1'b0);
        bif.button_middle = 1'b1;
        collect_burst(10, 700, lat, n, ed, eb);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (gx[i] != i % W || gy[i] != i / W || gc[i] != 0) bad++;
        end
        checks++;
        if (lat != 1 || n != 700) begin
            errors++;
            $display("FAIL clear_start_len: got lat=%0d n=%0d, want lat=1 n=700", lat, n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_start_pixels: got %0d wrong pixels, want 0", bad);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bif.plot !== 1'b0 || bif.busy !== 1'b0 || bif.x !== 10'd0 || bif.y !== 9'd0) begin
            errors++;
            $display("FAIL clear_abort: got plot=%b busy=%b x=%0d y=%0d, want 0 0 0 0",
                     bif.plot, bif.busy, bif.x, bif.y);
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        bif.button_middle = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_small_clear();
        int n, bad, lx, ly, first_x, first_y, first_c;
        bit got_done;
        sif.cell_x = 3'd1; sif.cell_y = 3'd1; sif.colour_sel = 3'd7; sif.button_left = 1'b1;
        n = 0; got_done = 1'b0;
        for (int k = 0; k < 100 && !got_done; k++) begin
            @(negedge clk);
            if (sif.plot) n++;
            if (sif.done) got_done = 1'b1;
        end
        checks++;
        if (n != 25 || !got_done) begin
            errors++;
            $display("FAIL small_paint: got n=%0d done=%b, want 25 1", n, got_done);
        end
        // Left stays held on the same cell: only the clear may draw
        sif.button_middle = 1'b1;
        n = 0; bad = 0; lx = -1; ly = -1; got_done = 1'b0;
        for (int k = 0; k < 1500 && !got_done; k++) begin
            @(negedge clk);
            if (sif.plot) begin
                if (int'(sif.x) != n % SW || int'(sif.y) != n / SW || sif.colour != 3'd0) bad++;
                lx = int'(sif.x); ly = int'(sif.y);
                n++;
                if (n == 10) sif.button_middle = 1'b0;
            end
            if (sif.done) got_done = 1'b1;
        end
        checks++;
        if (n != SW * SH || !got_done) begin
            errors++;
            $display("FAIL small_clear_len: got n=%0d done=%b, want %0d 1", n, got_done, SW * SH);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL small_clear_pixels: got %0d wrong pixels, want 0", bad);
        end
        checks++;
        if (lx != SW - 1 || ly != SH - 1) begin
            errors++;
            $display("FAIL small_clear_last: got (%0d,%0d), want (%0d,%0d)", lx, ly, SW - 1, SH - 1);
        end
        n = 0; got_done = 1'b0; first_x = -1; first_y = -1; first_c = -1;
        for (int k = 0; k < 100 && !got_done; k++) begin
            @(negedge clk);
            if (sif.plot) begin
                if (n == 0) begin
                    first_x = int'(sif.x); first_y = int'(sif.y); first_c = int'(sif.colour);
                end
                n++;
            end
            if (sif.done) got_done = 1'b1;
        end
        checks++;
        if (n != 25 || first_x != 5 || first_y != 5 || first_c != 7) begin
            errors++;
            $display("FAIL small_repaint: got n=%0d first=(%0d,%0d,%0d), want 25 (5,5,7)",
                     n, first_x, first_y, first_c);
        end
        sif.button_left = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 1'b0, 1'b0);
        bif.button_middle = 1'b0;
        sif.cell_x = 3'd0; sif.cell_y = 3'd0; sif.colour_sel = 3'd0;
        sif.button_left = 1'b0; sif.button_right = 1'b0; sif.button_middle = 1'b0;
        test_reset();
        test_first_paint();
        test_hold_dedup();
        test_right_and_priority();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_paint();
        test_random();
        test_clear_start();
        test_small_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
